// File: rtl/fp_preadder_pipe.sv
// ---------------------------------------------------------------------------
// fp_preadder_pipe
//
// Two-stage pre-adder for a floating-point add/sub datapath. Takes two
// packed operands and an add/sub mode bit over a valid/ready handshake. It
// produces the magnitude-ordered, exponent-aligned mantissas that the
// mantissa adder and normaliser consume. Special operands (NaN, inf, double
// zero) are resolved here and flagged so that they bypass the adder.
//
// Stage 1 : unpack, classify, special-case resolution, compare/swap,
//           exponent difference
// Stage 2 : right shift of the smaller mantissa with sticky collection
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   in_valid         operand pair valid
//   in_ready         pipe can accept this cycle (combinational from out_ready)
//   number_A/B       packed operands {sign, exponent, fraction}
//   op_sub           1 = A - B, 0 = A + B
//   out_valid        result valid
//   out_ready        consumer accepts the result
//   sign, exp        sign and effective exponent of the larger operand
//   mantis_great     aligned mantissa of the larger operand
//   mantis_small     aligned, shifted mantissa of the smaller operand
//                    (layout {carry, hidden, fraction, guard, round, sticky})
//   eff_sub          effective subtraction
//   special_result   final packed result when special_case = 1
//   special_case     result bypasses the adder
// ---------------------------------------------------------------------------
module fp_preadder_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W  = 1 + EXP_W + MAN_W,
    localparam int MW = MAN_W + 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     number_A,
    input  logic [W-1:0]     number_B,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign,
    output logic [EXP_W-1:0] exp,
    output logic [MW-1:0]    mantis_great,
    output logic [MW-1:0]    mantis_small,
    output logic             eff_sub,
    output logic [W-1:0]     special_result,
    output logic             special_case
);

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // -----------------------------------------------------------------------
    // Operand unpack and classification (index 0 = A, 1 = B)
    // -----------------------------------------------------------------------
    logic [W-1:0]     opnd   [2];
    logic [EXP_W-1:0] fexp   [2];
    logic [EXP_W-1:0] eexp   [2];
    logic [MAN_W-1:0] frac   [2];
    logic [MW-1:0]    mant   [2];
    logic [1:0]       sgn;
    logic [1:0]       hidden;
    logic [1:0]       is_zero;
    logic [1:0]       is_inf;
    logic [1:0]       is_nan;

    assign opnd[0] = number_A;
    assign opnd[1] = number_B;

    // B's sign is taken after the operation is folded into it, so every
    // later decision sees a plain addition of two signed operands.
    assign sgn[0] = opnd[0][W-1];
    assign sgn[1] = opnd[1][W-1] ^ op_sub;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            assign fexp[gi]    = opnd[gi][W-2 -: EXP_W];
            assign frac[gi]    = opnd[gi][MAN_W-1:0];
            assign hidden[gi]  = |fexp[gi];
            // Subnormals and zero share the minimum normal exponent; with the
            // hidden bit cleared this gives them the correct scale, so no
            // separate subnormal path is needed downstream.
            assign eexp[gi]    = hidden[gi] ? fexp[gi] : EXP_W'(1);
            assign mant[gi]    = {1'b0, hidden[gi], frac[gi], 3'b000};
            assign is_zero[gi] = !hidden[gi] && !(|frac[gi]);
            assign is_inf[gi]  = (fexp[gi] == EXP_ONES) && !(|frac[gi]);
            assign is_nan[gi]  = (fexp[gi] == EXP_ONES) &&  (|frac[gi]);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Special-case resolution (priority ordered)
    // -----------------------------------------------------------------------
    logic         spec_c;
    logic [W-1:0] spec_res_c;

    always_comb begin
        spec_c     = 1'b0;
        spec_res_c = '0;
        if (|is_nan) begin
            spec_c     = 1'b1;
            spec_res_c = QNAN;
        end else if ((&is_inf) && (sgn[0] != sgn[1])) begin
            // inf - inf
            spec_c     = 1'b1;
            spec_res_c = QNAN;
        end else if (is_inf[0]) begin
            spec_c     = 1'b1;
            spec_res_c = {sgn[0], EXP_ONES, {MAN_W{1'b0}}};
        end else if (is_inf[1]) begin
            spec_c     = 1'b1;
            spec_res_c = {sgn[1], EXP_ONES, {MAN_W{1'b0}}};
        end else if (&is_zero) begin
            // Only (-0) + (-0) keeps a negative sign.
            spec_c     = 1'b1;
            spec_res_c = {sgn[0] & sgn[1], {(W-1){1'b0}}};
        end
    end

    // -----------------------------------------------------------------------
    // Magnitude ordering and exponent difference
    // -----------------------------------------------------------------------
    // Comparing the raw {exp, frac} fields orders magnitudes directly, ties
    // going to A. The effective exponent is monotone in the raw field, so
    // the difference below can never go negative.
    logic             a_great_c;
    logic             sign_c;
    logic             eff_c;
    logic [EXP_W-1:0] exp_c;
    logic [EXP_W-1:0] d_c;
    logic [MW-1:0]    mg_c;
    logic [MW-1:0]    ms_c;

    assign a_great_c = opnd[0][W-2:0] >= opnd[1][W-2:0];

    always_comb begin
        sign_c = 1'b0;
        eff_c  = 1'b0;
        exp_c  = '0;
        d_c    = '0;
        mg_c   = '0;
        ms_c   = '0;
        if (!spec_c) begin
            eff_c = sgn[0] ^ sgn[1];
            if (a_great_c) begin
                sign_c = sgn[0];
                exp_c  = eexp[0];
                d_c    = eexp[0] - eexp[1];
                mg_c   = mant[0];
                ms_c   = mant[1];
            end else begin
                sign_c = sgn[1];
                exp_c  = eexp[1];
                d_c    = eexp[1] - eexp[0];
                mg_c   = mant[1];
                ms_c   = mant[0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Handshake and stage advance
    // -----------------------------------------------------------------------
    logic             ready_en_reg;
    logic             v1_reg;
    logic             s1_sign_reg;
    logic             s1_eff_reg;
    logic             s1_spec_reg;
    logic [W-1:0]     s1_spec_res_reg;
    logic [EXP_W-1:0] s1_exp_reg;
    logic [EXP_W-1:0] s1_d_reg;
    logic [MW-1:0]    s1_mg_reg;
    logic [MW-1:0]    s1_ms_reg;

    logic ld2;
    logic ld1;
    logic accept;

    assign ld2      = !out_valid || out_ready;
    assign ld1      = !v1_reg || ld2;
    // ready_en_reg holds in_ready low during reset and rises on the first
    // clock after release; the remaining term is !v1 | !v2 | out_ready.
    assign in_ready = ready_en_reg && ld1;
    assign accept   = in_valid && in_ready;

    // -----------------------------------------------------------------------
    // Stage 2 alignment: right shift with sticky OR of every lost bit
    // -----------------------------------------------------------------------
    logic [MW-1:0] shifted_c;
    logic [MW-1:0] mask_c;
    logic [MW-1:0] small_c;

    always_comb begin
        shifted_c = s1_ms_reg >> s1_d_reg;
        mask_c    = ~({MW{1'b1}} << s1_d_reg);
        if (32'(s1_d_reg) >= 32'(MW)) begin
            small_c = {{(MW-1){1'b0}}, |s1_ms_reg};
        end else begin
            small_c = shifted_c | {{(MW-1){1'b0}}, |(s1_ms_reg & mask_c)};
        end
    end

    // -----------------------------------------------------------------------
    // Pipeline registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_reg    <= 1'b0;
            v1_reg          <= 1'b0;
            s1_sign_reg     <= 1'b0;
            s1_eff_reg      <= 1'b0;
            s1_spec_reg     <= 1'b0;
            s1_spec_res_reg <= '0;
            s1_exp_reg      <= '0;
            s1_d_reg        <= '0;
            s1_mg_reg       <= '0;
            s1_ms_reg       <= '0;
            out_valid       <= 1'b0;
            sign            <= 1'b0;
            exp             <= '0;
            mantis_great    <= '0;
            mantis_small    <= '0;
            eff_sub         <= 1'b0;
            special_result  <= '0;
            special_case    <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;

            if (ld1) begin
                v1_reg <= accept;
                if (accept) begin
                    s1_sign_reg     <= sign_c;
                    s1_eff_reg      <= eff_c;
                    s1_spec_reg     <= spec_c;
                    s1_spec_res_reg <= spec_res_c;
                    s1_exp_reg      <= exp_c;
                    s1_d_reg        <= d_c;
                    s1_mg_reg       <= mg_c;
                    s1_ms_reg       <= ms_c;
                end
            end

            // Data only moves with a valid pair, so a stalled or drained
            // output keeps its last value.
            if (ld2) begin
                out_valid <= v1_reg;
                if (v1_reg) begin
                    sign           <= s1_sign_reg;
                    exp            <= s1_exp_reg;
                    mantis_great   <= s1_mg_reg;
                    mantis_small   <= s1_spec_reg ? '0 : small_c;
                    eff_sub        <= s1_eff_reg;
                    special_result <= s1_spec_res_reg;
                    special_case   <= s1_spec_reg;
                end
            end
        end
    end

endmodule
